// File: rtl/fallthrough_small_fifo_pkg.sv
// ---------------------------------------------------------------------------
// fallthrough_small_fifo_pkg
//   Shared widths for the user data path. A data-path word is a control
//   byte followed by a 64-bit data field. The FIFO word width defaults to
//   the sum of the two.
//   Ports: none (package only).
// ---------------------------------------------------------------------------
package fallthrough_small_fifo_pkg;

   localparam int CTRL_WIDTH = 8;
   localparam int DATA_WIDTH = 64;
   localparam int WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;

endpackage : fallthrough_small_fifo_pkg

// File: rtl/fallthrough_small_fifo.sv
// ---------------------------------------------------------------------------
// fallthrough_small_fifo
//   Small first-word-fall-through FIFO used as the input buffer of
//   packet-processing modules. The head word is always presented on dout
//   while empty is low, and rd_en pops it.
//
//   Ports:
//     clk          single clock; all logic on the rising edge
//     reset        synchronous, active-high; discards all contents
//     din          write data
//     wr_en        write strobe, one word per cycle
//     rd_en        pop the head word
//     dout         head word, valid whenever empty = 0
//     full         occupancy == depth
//     nearly_full  occupancy >= NEARLY_FULL (drives upstream in_rdy = !nearly_full)
//     prog_full    occupancy >= PROG_FULL_THRESHOLD
//     empty        occupancy == 0
//
//   Handshake: a word is transferred in on a rising edge when wr_en = 1 and
//   the FIFO is not full, or when it is full and rd_en = 1 pops a word on
//   the same edge. A word is transferred out on a rising edge when
//   rd_en = 1 and empty = 0. Requests that do not meet these conditions
//   are dropped with no change to pointers, count or contents.
// ---------------------------------------------------------------------------
module fallthrough_small_fifo
   import fallthrough_small_fifo_pkg::*;
#(
   parameter int WIDTH               = WORD_WIDTH,
   parameter int MAX_DEPTH_BITS      = 3,
   parameter int NEARLY_FULL         = 2**MAX_DEPTH_BITS - 1,
   parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             prog_full,
   output logic             empty
);

   localparam int DEPTH   = 2**MAX_DEPTH_BITS;
   localparam int CNT_W   = MAX_DEPTH_BITS + 1;

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] NF_CNT    = CNT_W'(NEARLY_FULL);
   localparam logic [CNT_W-1:0] PF_CNT    = CNT_W'(PROG_FULL_THRESHOLD);

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [CNT_W-1:0]          count;

   logic do_write;
   logic do_read;

   // A pop on the same edge frees the slot the write lands in, so a full
   // FIFO still accepts a write when it is also being read.
   assign do_read  = rd_en && !empty;
   assign do_write = wr_en && (!full || rd_en);

   // Flags depend only on the registered count. nearly_full and full are
   // kept as separate decodes so the upstream in_rdy backpressure keeps a
   // slot of slack for a word already in flight.
   assign empty       = (count == '0);
   assign full        = (count == DEPTH_CNT);
   assign nearly_full = (count >= NF_CNT);
   assign prog_full   = (count >= PF_CNT);

   // Fall-through: the head slot is read asynchronously, so a word written
   // into an empty FIFO is visible right after its write edge, and the next
   // word is visible right after a pop edge.
   assign dout = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_write, do_read})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_write && !reset) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule : fallthrough_small_fifo

// File: tb/tb_fallthrough_small_fifo.sv
// ---------------------------------------------------------------------------
// tb_fallthrough_small_fifo
//   Directed self-checking bench for fallthrough_small_fifo (default
//   parameters: 72-bit words, depth 8, nearly_full at 7, prog_full at 5).
// ---------------------------------------------------------------------------
module tb_fallthrough_small_fifo;

   localparam int W = 72;

   logic         clk;
   logic         reset;
   logic [W-1:0] din;
   logic         wr_en;
   logic         rd_en;
   logic [W-1:0] dout;
   logic         full;
   logic         nearly_full;
   logic         prog_full;
   logic         empty;

   int total;
   int bad;
   int cnt;
   logic [W-1:0] exp_q[$];

   fallthrough_small_fifo dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .dout        (dout),
      .full        (full),
      .nearly_full (nearly_full),
      .prog_full   (prog_full),
      .empty       (empty)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   // Advance past one rising edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Flags packed as {empty, full, nearly_full, prog_full}.
   function automatic logic [3:0] exp_flags(input int c);
      return {c == 0, c == 8, c >= 7, c >= 5};
   endfunction

   task automatic chk_flags(input string tag);
      chk(tag, W'({empty, full, nearly_full, prog_full}), W'(exp_flags(cnt)));
   endtask

   task automatic push(input logic [W-1:0] d);
      din   = d;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      exp_q.push_back(d);
      cnt++;
   endtask

   task automatic pop_check(input string tag);
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk(tag, dout, e);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      cnt--;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      total = 0;
      bad   = 0;
      cnt   = 0;
      reset = 1'b1;
      din   = '0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Idle after reset: flags stay at their reset values.
      for (int i = 0; i < 10; i++) begin
         chk("idle_flags", W'({empty, full, nearly_full, prog_full}), W'(4'b1000));
         tick();
      end

      // Single word falls through, then one pop empties the FIFO.
      push(72'h01_0000000000000001);
      chk("single_empty", W'(empty), W'(1'b0));
      chk("single_dout", dout, 72'h01_0000000000000001);
      pop_check("single_pop_dout");
      chk("single_after_pop", W'(empty), W'(1'b1));

      // Fill to depth; watch thresholds at 5, 7 and 8.
      for (int i = 0; i < 8; i++) begin
         push(W'(i));
         chk_flags("fill_flags");
      end
      // Ninth write while full with no pop is dropped.
      din   = 72'hFF_FFFFFFFFFFFFFFFF;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      chk_flags("overflow_flags");
      chk("overflow_head", dout, 72'h0);
      for (int i = 0; i < 8; i++) begin
         pop_check("drain_dout");
         chk_flags("drain_flags");
      end

      // Read while empty is ignored.
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk_flags("underflow_flags");

      // Hold occupancy at 4 with simultaneous write and pop.
      for (int i = 0; i < 4; i++) push(W'(72'h100 + i));
      chk_flags("hold_start_flags");
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] e;
         logic [W-1:0] d;
         e = exp_q.pop_front();
         d = W'(72'h104 + i);
         chk("hold_dout", dout, e);
         din   = d;
         wr_en = 1'b1;
         rd_en = 1'b1;
         tick();
         exp_q.push_back(d);
         chk_flags("hold_flags");
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      for (int i = 0; i < 4; i++) pop_check("hold_drain_dout");
      chk_flags("hold_end_flags");

      // Count 1: simultaneous write 0xAA and pop shows the new word.
      push(72'h55);
      chk("c1_head", dout, 72'h55);
      din   = 72'hAA;
      wr_en = 1'b1;
      rd_en = 1'b1;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(72'hAA);
      chk("c1_empty", W'(empty), W'(1'b0));
      chk("c1_dout", dout, 72'hAA);
      pop_check("c1_pop_dout");
      chk_flags("c1_end_flags");

      // Wrap-around: full with simultaneous write and pop keeps count 8.
      for (int i = 0; i < 8; i++) push(W'(72'h400 + i));
      chk_flags("wrap_full_flags");
      chk("wrap_head", dout, 72'h400);
      din   = 72'h408;
      wr_en = 1'b1;
      rd_en = 1'b1;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(72'h408);
      chk_flags("wrap_rw_flags");
      for (int i = 0; i < 8; i++) pop_check("wrap_drain_dout");
      chk_flags("wrap_end_flags");

      // Fill to 6, reset with a write pending: everything is discarded.
      for (int i = 0; i < 6; i++) push(W'(72'h200 + i));
      chk_flags("pre_reset_flags");
      reset = 1'b1;
      din   = 72'h999;
      wr_en = 1'b1;
      tick();
      reset = 1'b0;
      wr_en = 1'b0;
      exp_q.delete();
      cnt = 0;
      chk("reset_flags", W'({empty, full, nearly_full, prog_full}), W'(4'b1000));
      push(72'h300);
      chk("post_reset_dout", dout, 72'h300);
      chk_flags("post_reset_flags");
      push(72'h301);
      pop_check("post_reset_pop0");
      pop_check("post_reset_pop1");
      chk_flags("final_flags");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fallthrough_small_fifo
